// File: rtl/barrier_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// barrier_pkg
//   Shared types and helpers for the parking-barrier sequencer slice.
//   - seq_state_t : sequencer FSM states
//   - dir_t       : travel direction of the vehicle being served
//   - tmr_width() : width of the shared motor/wait down-counter
// ---------------------------------------------------------------------------
package barrier_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RAISE    = 3'd1,
    WAIT_CAR = 3'd2,
    PASSING  = 3'd3,
    LOWER    = 3'd4
  } seq_state_t;

  typedef enum logic {
    DIR_IN  = 1'b0,
    DIR_OUT = 1'b1
  } dir_t;

  // The timer is loaded with (ticks - 2), so a counter able to hold the
  // larger of the two durations is always wide enough.
  function automatic int tmr_width(input int open_ticks, input int pass_timeout);
    int longest;
    longest = (open_ticks > pass_timeout) ? open_ticks : pass_timeout;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/barrier_sequencer_if.sv
// ---------------------------------------------------------------------------
// barrier_sequencer_if
//   Request/acknowledge handshake between the entry/exit reader lanes and
//   the barrier sequencer.
//   in_req/in_ok     entry request level and credential valid
//   out_req/out_ok   exit request level and credential valid
//   in_ack/in_grant  1-cycle consume pulse for entry, grant valid with ack
//   out_ack/out_grant 1-cycle consume pulse for exit, grant valid with ack
//   master : the lane side (drives requests)
//   slave  : the sequencer side (drives acks/grants)
// ---------------------------------------------------------------------------
interface barrier_sequencer_if;

  logic in_req;
  logic in_ok;
  logic out_req;
  logic out_ok;
  logic in_ack;
  logic in_grant;
  logic out_ack;
  logic out_grant;

  modport master (
    output in_req, in_ok, out_req, out_ok,
    input  in_ack, in_grant, out_ack, out_grant
  );

  modport slave (
    input  in_req, in_ok, out_req, out_ok,
    output in_ack, in_grant, out_ack, out_grant
  );

endinterface

// File: rtl/barrier_sequencer_timer.sv
// ---------------------------------------------------------------------------
// barrier_timer
//   Loadable down-counter shared by the RAISE, WAIT_CAR and LOWER phases.
//   clk      in  system clock, rising edge
//   reset    in  synchronous, active-low
//   load     in  load pulse (registered by the sequencer on state entry)
//   load_val in  value loaded into the counter
//   done     out counter has reached zero and no load is pending
//
//   Because load is itself a registered pulse, a phase of N cycles is
//   obtained by loading N-2: one cycle with load high, then N-2 .. 0.
//   done is masked while load is high so a stale zero from the previous
//   phase can never end the new phase early.
// ---------------------------------------------------------------------------
module barrier_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  localparam logic [W-1:0] ZERO_C = {W{1'b0}};
  localparam logic [W-1:0] ONE_C  = W'(1'b1);

  logic [W-1:0] cnt_r;

  // Down-counter: load has priority, otherwise count toward zero and hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r <= ZERO_C;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != ZERO_C) begin
      cnt_r <= cnt_r - ONE_C;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = ~load & (cnt_r == ZERO_C);

endmodule

// File: rtl/barrier_sequencer.sv
// ---------------------------------------------------------------------------
// barrier_sequencer
//   Sequences the single parking barrier shared by the entry and exit lanes:
//   round-robin arbitration of lane requests, motor control through
//   raise / wait-for-vehicle / pass / lower, and lot occupancy tracking.
//
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low
//   lanes      slave modport of barrier_sequencer_if (req/ok in, ack/grant out)
//   loop_det   in   vehicle-presence loop under the barrier (already synchronised)
//   motor_up   out  raise barrier, high only in RAISE
//   motor_dn   out  lower barrier, high only in LOWER
//   busy       out  sequencer not idle
//   occupancy  out  vehicles currently inside
//   full       out  occupancy == CAPACITY
//
//   All outputs are registered. OPEN_TICKS and PASS_TIMEOUT must be >= 2.
// ---------------------------------------------------------------------------
module barrier_sequencer
  import barrier_pkg::*;
#(
  parameter  int OPEN_TICKS   = 4,
  parameter  int PASS_TIMEOUT = 10,
  parameter  int CAPACITY     = 2,
  localparam int CNT_W        = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  barrier_sequencer_if.slave   lanes,
  input  logic                 loop_det,
  output logic                 motor_up,
  output logic                 motor_dn,
  output logic                 busy,
  output logic [CNT_W-1:0]     occupancy,
  output logic                 full
);

  localparam int TW = tmr_width(OPEN_TICKS, PASS_TIMEOUT);

  localparam logic [TW-1:0]    OPEN_LD_C = TW'(OPEN_TICKS - 2);
  localparam logic [TW-1:0]    WAIT_LD_C = TW'(PASS_TIMEOUT - 2);
  localparam logic [TW-1:0]    TMR_ZERO_C = {TW{1'b0}};
  localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] OCC_ONE_C = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] OCC_ZERO_C = {CNT_W{1'b0}};

  seq_state_t       state_r;
  dir_t             dir_r;
  dir_t             rr_r;
  logic             in_ack_r;
  logic             in_grant_r;
  logic             out_ack_r;
  logic             out_grant_r;
  logic             motor_up_r;
  logic             motor_dn_r;
  logic             busy_r;
  logic [CNT_W-1:0] occ_r;
  logic             full_r;
  logic             tmr_load_r;
  logic [TW-1:0]    tmr_val_r;

  logic             tmr_done_s;
  logic             win_valid_s;
  dir_t             win_dir_s;
  logic             win_grant_s;
  logic [CNT_W-1:0] occ_next_s;

  barrier_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load_r),
    .load_val (tmr_val_r),
    .done     (tmr_done_s)
  );

  // Arbitration: round-robin pointer breaks ties, a lone request wins outright.
  always_comb begin
    win_valid_s = 1'b0;
    win_dir_s   = rr_r;
    win_grant_s = 1'b0;
    if (lanes.in_req && lanes.out_req) begin
      win_valid_s = 1'b1;
      win_dir_s   = rr_r;
    end else if (lanes.in_req) begin
      win_valid_s = 1'b1;
      win_dir_s   = DIR_IN;
    end else if (lanes.out_req) begin
      win_valid_s = 1'b1;
      win_dir_s   = DIR_OUT;
    end else begin
      win_valid_s = 1'b0;
      win_dir_s   = rr_r;
    end
    if (win_dir_s == DIR_IN) begin
      win_grant_s = lanes.in_ok & ~full_r;
    end else begin
      win_grant_s = lanes.out_ok;
    end
  end

  // Occupancy after a vehicle clears the loop: saturating in both directions.
  always_comb begin
    occ_next_s = occ_r;
    if (dir_r == DIR_IN) begin
      if (occ_r < CAP_C) begin
        occ_next_s = occ_r + OCC_ONE_C;
      end else begin
        occ_next_s = CAP_C;
      end
    end else begin
      if (occ_r != OCC_ZERO_C) begin
        occ_next_s = occ_r - OCC_ONE_C;
      end else begin
        occ_next_s = OCC_ZERO_C;
      end
    end
  end

  // Sequencer FSM with registered outputs, pointer, occupancy and timer loads.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      dir_r       <= DIR_IN;
      rr_r        <= DIR_IN;
      in_ack_r    <= 1'b0;
      in_grant_r  <= 1'b0;
      out_ack_r   <= 1'b0;
      out_grant_r <= 1'b0;
      motor_up_r  <= 1'b0;
      motor_dn_r  <= 1'b0;
      busy_r      <= 1'b0;
      occ_r       <= OCC_ZERO_C;
      full_r      <= 1'b0;
      tmr_load_r  <= 1'b0;
      tmr_val_r   <= TMR_ZERO_C;
    end else begin
      in_ack_r    <= 1'b0;
      in_grant_r  <= 1'b0;
      out_ack_r   <= 1'b0;
      out_grant_r <= 1'b0;
      tmr_load_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          // The cycle right after an ack is skipped so a requester that is
          // still dropping its req is not served twice.
          if (win_valid_s && !in_ack_r && !out_ack_r) begin
            if (win_dir_s == DIR_IN) begin
              in_ack_r   <= 1'b1;
              in_grant_r <= win_grant_s;
            end else begin
              out_ack_r   <= 1'b1;
              out_grant_r <= win_grant_s;
            end
            rr_r <= (win_dir_s == DIR_IN) ? DIR_OUT : DIR_IN;
            if (win_grant_s) begin
              dir_r      <= win_dir_s;
              state_r    <= RAISE;
              motor_up_r <= 1'b1;
              motor_dn_r <= 1'b0;
              busy_r     <= 1'b1;
              tmr_load_r <= 1'b1;
              tmr_val_r  <= OPEN_LD_C;
            end else begin
              state_r    <= IDLE;
              motor_up_r <= 1'b0;
              motor_dn_r <= 1'b0;
              busy_r     <= 1'b0;
            end
          end else begin
            state_r    <= IDLE;
            motor_up_r <= 1'b0;
            motor_dn_r <= 1'b0;
            busy_r     <= 1'b0;
          end
        end
        RAISE: begin
          if (tmr_done_s) begin
            state_r    <= WAIT_CAR;
            motor_up_r <= 1'b0;
            tmr_load_r <= 1'b1;
            tmr_val_r  <= WAIT_LD_C;
          end else begin
            state_r    <= RAISE;
            motor_up_r <= 1'b1;
          end
        end
        WAIT_CAR: begin
          if (loop_det) begin
            state_r <= PASSING;
          end else if (tmr_done_s) begin
            state_r    <= LOWER;
            motor_dn_r <= 1'b1;
            tmr_load_r <= 1'b1;
            tmr_val_r  <= OPEN_LD_C;
          end else begin
            state_r <= WAIT_CAR;
          end
        end
        PASSING: begin
          // The vehicle is counted when it clears the loop, not when it arrives.
          if (!loop_det) begin
            state_r    <= LOWER;
            motor_dn_r <= 1'b1;
            tmr_load_r <= 1'b1;
            tmr_val_r  <= OPEN_LD_C;
            occ_r      <= occ_next_s;
            full_r     <= (occ_next_s == CAP_C);
          end else begin
            state_r <= PASSING;
          end
        end
        LOWER: begin
          // Something under the barrier while lowering: reverse and re-raise.
          if (loop_det) begin
            state_r    <= RAISE;
            motor_dn_r <= 1'b0;
            motor_up_r <= 1'b1;
            tmr_load_r <= 1'b1;
            tmr_val_r  <= OPEN_LD_C;
          end else if (tmr_done_s) begin
            state_r    <= IDLE;
            motor_dn_r <= 1'b0;
            busy_r     <= 1'b0;
          end else begin
            state_r    <= LOWER;
            motor_dn_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= IDLE;
          motor_up_r <= 1'b0;
          motor_dn_r <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign lanes.in_ack    = in_ack_r;
  assign lanes.in_grant  = in_grant_r;
  assign lanes.out_ack   = out_ack_r;
  assign lanes.out_grant = out_grant_r;
  assign motor_up        = motor_up_r;
  assign motor_dn        = motor_dn_r;
  assign busy            = busy_r;
  assign occupancy       = occ_r;
  assign full            = full_r;

endmodule

// File: tb/tb_barrier_sequencer.sv
// ---------------------------------------------------------------------------
// tb_barrier_sequencer
//   Directed bench for barrier_sequencer with OPEN_TICKS=4, PASS_TIMEOUT=10,
//   CAPACITY=2. Inputs change 1 time unit after the rising edge and outputs
//   are sampled at the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_barrier_sequencer;

  logic       clk;
  logic       reset;
  logic       loop_det;
  logic       motor_up;
  logic       motor_dn;
  logic       busy;
  logic [1:0] occupancy;
  logic       full;

  int checks;
  int failures;

  barrier_sequencer_if lanes();

  barrier_sequencer #(
    .OPEN_TICKS   (4),
    .PASS_TIMEOUT (10),
    .CAPACITY     (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .lanes     (lanes),
    .loop_det  (loop_det),
    .motor_up  (motor_up),
    .motor_dn  (motor_dn),
    .busy      (busy),
    .occupancy (occupancy),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for either ack, then drop the acknowledged request.
  task automatic wait_ack(output int lat, output logic ain, output logic gin,
                          output logic aout, output logic gout);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!(lanes.in_ack === 1'b1 || lanes.out_ack === 1'b1) && lat < 40);
    ain  = lanes.in_ack;
    gin  = lanes.in_grant;
    aout = lanes.out_ack;
    gout = lanes.out_grant;
    if (ain === 1'b1) lanes.in_req = 1'b0;
    if (aout === 1'b1) lanes.out_req = 1'b0;
  endtask

  // Run one transit from the ack cycle (k=0) until busy drops, driving
  // loop_det high in [r1,f1) and [r2,f2) and counting output activity.
  task automatic run_transit(input int r1, input int f1, input int r2, input int f2,
                             output int up, output int dn, output int still,
                             output int bsy, output int acks, output int both);
    int k;
    k = 0; up = 0; dn = 0; still = 0; bsy = 0; acks = 0; both = 0;
    while (k < 100) begin
      loop_det = ((k >= r1 && k < f1) || (k >= r2 && k < f2)) ? 1'b1 : 1'b0;
      if (busy !== 1'b1) break;
      bsy++;
      if (motor_up === 1'b1) up++;
      if (motor_dn === 1'b1) dn++;
      if (motor_up === 1'b0 && motor_dn === 1'b0) still++;
      if (motor_up === 1'b1 && motor_dn === 1'b1) both++;
      if (k > 0 && (lanes.in_ack === 1'b1 || lanes.out_ack === 1'b1)) acks++;
      step();
      k++;
    end
    loop_det = 1'b0;
  endtask

  initial begin
    int lat, up, dn, still, bsy, acks, both, act;
    logic ain, gin, aout, gout;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    loop_det = 1'b0;
    lanes.in_req = 1'b0;
    lanes.in_ok = 1'b0;
    lanes.out_req = 1'b0;
    lanes.out_ok = 1'b0;

    // Reset state.
    step(); step(); step();
    check("rst_motor_up", motor_up, 1'b0);
    check("rst_motor_dn", motor_dn, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_occ", occupancy, 2'd0);
    check("rst_full", full, 1'b0);
    check("rst_acks", {lanes.in_ack, lanes.in_grant, lanes.out_ack, lanes.out_grant}, 4'd0);
    reset = 1'b1;
    step();

    // Simultaneous requests after reset: entry first, exit waits un-acked.
    lanes.in_req = 1'b1; lanes.in_ok = 1'b1;
    lanes.out_req = 1'b1; lanes.out_ok = 1'b1;
    wait_ack(lat, ain, gin, aout, gout);
    check("pair1_lat", lat, 1);
    check("pair1_in_ack", ain, 1'b1);
    check("pair1_in_grant", gin, 1'b1);
    check("pair1_out_ack", aout, 1'b0);
    check("pair1_motor_up", motor_up, 1'b1);
    run_transit(6, 8, -1, -1, up, dn, still, bsy, acks, both);
    check("entry_up_cycles", up, 4);
    check("entry_dn_cycles", dn, 4);
    check("entry_still_cycles", still, 5);
    check("entry_busy_cycles", bsy, 13);
    check("entry_no_acks", acks, 0);
    check("entry_no_both", both, 0);
    check("entry_occ", occupancy, 2'd1);
    check("entry_full", full, 1'b0);

    // Pending exit served in the first IDLE cycle.
    wait_ack(lat, ain, gin, aout, gout);
    check("pair1_exit_lat", lat, 1);
    check("pair1_exit_ack", aout, 1'b1);
    check("pair1_exit_grant", gout, 1'b1);
    run_transit(6, 8, -1, -1, up, dn, still, bsy, acks, both);
    check("exit_busy_cycles", bsy, 13);
    check("exit_occ", occupancy, 2'd0);

    // Exit at occupancy 0: granted, occupancy saturates at 0.
    lanes.out_req = 1'b1; lanes.out_ok = 1'b1;
    wait_ack(lat, ain, gin, aout, gout);
    check("exit0_ack", aout, 1'b1);
    check("exit0_grant", gout, 1'b1);
    run_transit(6, 8, -1, -1, up, dn, still, bsy, acks, both);
    check("exit0_occ", occupancy, 2'd0);

    // Entry granted but no vehicle: WAIT_CAR times out after 10 cycles.
    lanes.in_req = 1'b1; lanes.in_ok = 1'b1;
    wait_ack(lat, ain, gin, aout, gout);
    check("tmo_in_grant", gin, 1'b1);
    run_transit(-1, -1, -1, -1, up, dn, still, bsy, acks, both);
    check("tmo_up_cycles", up, 4);
    check("tmo_wait_cycles", still, 10);
    check("tmo_dn_cycles", dn, 4);
    check("tmo_busy_cycles", bsy, 18);
    check("tmo_occ", occupancy, 2'd0);

    // Pointer now favours exit: simultaneous pair serves exit first.
    lanes.in_req = 1'b1; lanes.in_ok = 1'b1;
    lanes.out_req = 1'b1; lanes.out_ok = 1'b1;
    wait_ack(lat, ain, gin, aout, gout);
    check("pair2_out_ack", aout, 1'b1);
    check("pair2_in_ack", ain, 1'b0);
    run_transit(6, 8, -1, -1, up, dn, still, bsy, acks, both);
    check("pair2_exit_occ", occupancy, 2'd0);
    check("pair2_no_acks", acks, 0);

    // Entry with timeout then loop_det at LOWER cycle 2: reversal, car passes once.
    wait_ack(lat, ain, gin, aout, gout);
    check("rev_lat", lat, 1);
    check("rev_in_ack", ain, 1'b1);
    check("rev_in_grant", gin, 1'b1);
    run_transit(15, 22, -1, -1, up, dn, still, bsy, acks, both);
    check("rev_up_cycles", up, 8);
    check("rev_dn_cycles", dn, 6);
    check("rev_still_cycles", still, 13);
    check("rev_busy_cycles", bsy, 27);
    check("rev_no_both", both, 0);
    check("rev_occ", occupancy, 2'd1);

    // Second entry fills the lot.
    lanes.in_req = 1'b1; lanes.in_ok = 1'b1;
    wait_ack(lat, ain, gin, aout, gout);
    check("fill_grant", gin, 1'b1);
    run_transit(6, 8, -1, -1, up, dn, still, bsy, acks, both);
    check("fill_occ", occupancy, 2'd2);
    check("fill_full", full, 1'b1);

    // Entry while full: acked but denied, barrier stays down.
    lanes.in_req = 1'b1; lanes.in_ok = 1'b1;
    wait_ack(lat, ain, gin, aout, gout);
    check("deny_full_ack", ain, 1'b1);
    check("deny_full_grant", gin, 1'b0);
    act = 0;
    for (int i = 0; i < 3; i++) begin
      if (motor_up !== 1'b0 || motor_dn !== 1'b0 || busy !== 1'b0) act++;
      step();
    end
    check("deny_full_idle", act, 0);
    check("deny_full_occ", occupancy, 2'd2);

    // Exit with bad credential: denied.
    lanes.out_req = 1'b1; lanes.out_ok = 1'b0;
    wait_ack(lat, ain, gin, aout, gout);
    check("deny_exit_ack", aout, 1'b1);
    check("deny_exit_grant", gout, 1'b0);
    step();
    check("deny_exit_busy", busy, 1'b0);

    // Reset during RAISE aborts immediately.
    step();
    lanes.out_req = 1'b1; lanes.out_ok = 1'b1;
    wait_ack(lat, ain, gin, aout, gout);
    check("abort_grant", gout, 1'b1);
    check("abort_raising", motor_up, 1'b1);
    reset = 1'b0;
    step();
    check("abort_outputs",
          {lanes.in_ack, lanes.in_grant, lanes.out_ack, lanes.out_grant,
           motor_up, motor_dn, busy, full}, 8'd0);
    check("abort_occ", occupancy, 2'd0);
    reset = 1'b1;
    step();
    check("abort_stays_idle", {motor_up, motor_dn, busy}, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
